instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Instruction fetch stage that supplies Instr to the control decoder.
//   - Consumes the decoder's PC_sel / PC_LdEn.
//   - Owns the PC register and issues req/ack reads to instruction memory.
//   - Presents each fetched word to the decode stage with a valid/ready handshake.
//   - Instr = 0 is a nop and is the reset/idle value of Instr.
// PARAMETERS
//   ADDR_W    32  PC and Imem_Addr width
//   RESET_PC  0   PC value after reset; must be word aligned
// PORTS
//   Clk          in   1       single clock, rising edge
//   Reset        in   1       asynchronous, active-low reset
//   PC_sel       in   1       0: next PC = PC+4; 1: next PC = PC+4+(PC_Immed<<2)
//   PC_LdEn      in   1       1: advance PC at handshake; 0: hold PC and refetch same word
//   PC_Immed     in   32      sign-extended branch offset, in words
//   Imem_Req     out  1       read request to instruction memory
//   Imem_Addr    out  ADDR_W  read address; equals PC
//   Imem_Ack     in   1       one-cycle pulse; Imem_RdData valid in the same cycle
//   Imem_RdData  in   32      instruction word
//   Instr        out  32      instruction to decoder
//   Instr_Valid  out  1       Instr holds a fetched word
//   Instr_Ready  in   1       decode stage accepts Instr
//   PC           out  ADDR_W  address of the word currently in Instr
// BEHAVIOUR
//   Reset (Reset=0, async):
//     PC=RESET_PC, Instr=0, Instr_Valid=0, Imem_Req=0, state=IDLE.
//     Any outstanding request is abandoned. Imem_Req drops immediately.
//   States:
//     IDLE -> REQ     Unconditionally, on the first clock after reset release.
//     REQ             Imem_Req=1, Imem_Addr=PC held stable until Imem_Ack.
//                     On Imem_Ack: Instr<=Imem_RdData, Instr_Valid<=1, -> HOLD.
//     HOLD            Instr and Instr_Valid held stable until Instr_Ready=1.
//                     On Instr_Valid&Instr_Ready, sample PC_sel/PC_LdEn/PC_Immed;
//                     update PC per the rules below; Instr_Valid<=0; -> REQ.
//   PC update at handshake:
//     PC_LdEn=0                PC unchanged; the same word is refetched.
//     PC_LdEn=1, PC_sel=0      PC <= PC+4.
//     PC_LdEn=1, PC_sel=1      PC <= PC+4+(PC_Immed<<2).
//   Latency:
//     Imem_Req rises 1 cycle after entering REQ.
//     Instr_Valid rises the cycle after Imem_Ack.
//     Minimum 3 cycles per instruction with zero-wait memory.
//   Arithmetic and boundaries:
//     - All PC arithmetic is modulo 2^ADDR_W; wrap-around is silent.
//     - PC[1:0] is always 0.
//     - Imem_Ack outside REQ is ignored.
//     - Instr_Ready outside HOLD is ignored.
//     - Instr is not cleared when Instr_Valid falls; it keeps the last word.
//       The decoder qualifies Instr with Instr_Valid.
//     - Reset asserted in any state returns to IDLE within the same cycle (async).
// STRUCTURE
//   Shared package/header mips_defs.vh:
//     - RESET_PC default, fetch state encodings (IDLE/REQ/HOLD)
//     - NOP word constant 32'h0
//   Sub-module pc_next: combinational next-PC from PC, PC_sel, PC_LdEn,
//     PC_Immed. Reused by the branch unit.
//   This block: FSM, PC register, instruction register.
// TESTING
//   1. Reset release, zero-wait memory, Instr_Ready=1, PC_LdEn=1, PC_sel=0
//      -> Imem_Addr sequence 0,4,8,C; each Instr matches memory.
//   2. Ack delayed 5 cycles -> Imem_Req and Imem_Addr held stable for all
//      5 cycles; Instr_Valid rises the cycle after Ack.
//   3. At PC=0x10, PC_sel=1, PC_Immed=-2 (0xFFFFFFFE) -> next Imem_Addr=0x0C.
//   4. PC_LdEn=0 at handshake with PC=0x20 -> next Imem_Addr=0x20; same word re-presented.
//   5. Instr_Ready=0 for 4 cycles in HOLD -> Instr/Instr_Valid/PC stable;
//      Imem_Req stays 0.
//   6. PC=0xFFFFFFFC, PC_LdEn=1, PC_sel=0 -> next Imem_Addr=0x0.
//      Reset asserted mid-REQ -> Imem_Req=0, Instr=0 immediately.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: fetch FSM encoding,
// nop word and default reset PC.
`default_nettype none

package instr_fetch_unit_pkg;

  localparam int unsigned INSTR_W          = 32;
  localparam int unsigned RESET_PC_DEFAULT = 0;
  localparam logic [INSTR_W-1:0] NOP_WORD  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_unit_pc_next.sv
// Combinational next-PC: hold, sequential (+4) or word-offset branch.
// All arithmetic wraps modulo 2^ADDR_W.
`default_nettype none

module instr_fetch_unit_pc_next
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0]  pc,
  input  logic               pc_sel,
  input  logic               pc_ld_en,
  input  logic [INSTR_W-1:0] pc_immed,
  output logic [ADDR_W-1:0]  pc_next
);

  logic [ADDR_W-1:0] imm_ext;
  logic [ADDR_W-1:0] pc_seq;
  logic [ADDR_W-1:0] pc_branch;

  // The word offset is sign-extended (or truncated) to the PC width before scaling.
  if (ADDR_W > INSTR_W) begin : g_imm_sext
    assign imm_ext = {{(ADDR_W-INSTR_W){pc_immed[INSTR_W-1]}}, pc_immed};
  end else begin : g_imm_trunc
    assign imm_ext = pc_immed[ADDR_W-1:0];
  end

  assign pc_seq    = pc + ADDR_W'(4);
  assign pc_branch = pc_seq + (imm_ext << 2);

  always_comb begin
    pc_next = pc;
    if (pc_ld_en) begin
      pc_next = pc_sel ? pc_branch : pc_seq;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues req/ack reads to instruction
// memory and presents each word to decode over a valid/ready handshake.
`default_nettype none

module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               PC_sel,
  input  logic               PC_LdEn,
  input  logic [INSTR_W-1:0] PC_Immed,
  output logic               Imem_Req,
  output logic [ADDR_W-1:0]  Imem_Addr,
  input  logic               Imem_Ack,
  input  logic [INSTR_W-1:0] Imem_RdData,
  output logic [INSTR_W-1:0] Instr,
  output logic               Instr_Valid,
  input  logic               Instr_Ready,
  output logic [ADDR_W-1:0]  PC
);

  fetch_state_t       state;
  fetch_state_t       state_nxt;
  logic               req_reg;
  logic               valid_reg;
  logic [INSTR_W-1:0] instr_reg;
  logic [ADDR_W-1:0]  pc_reg;
  logic [ADDR_W-1:0]  pc_nxt;
  logic               fetch_done;
  logic               handshake;

  // An ack only counts while a request is actually on the bus.
  assign fetch_done = (state == ST_REQ) && req_reg && Imem_Ack;
  assign handshake  = (state == ST_HOLD) && valid_reg && Instr_Ready;

  instr_fetch_unit_pc_next #(
    .ADDR_W (ADDR_W)
  ) u_pc_next (
    .pc       (pc_reg),
    .pc_sel   (PC_sel),
    .pc_ld_en (PC_LdEn),
    .pc_immed (PC_Immed),
    .pc_next  (pc_nxt)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: state_nxt = ST_REQ;
      ST_REQ:  if (fetch_done) state_nxt = ST_HOLD;
      ST_HOLD: if (handshake)  state_nxt = ST_REQ;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request is registered from the state, so it rises one cycle into REQ
  // and falls on the cycle after the ack.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      req_reg <= 1'b0;
    end else begin
      req_reg <= (state == ST_REQ) && !fetch_done;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      instr_reg <= NOP_WORD;
      valid_reg <= 1'b0;
    end else if (fetch_done) begin
      instr_reg <= Imem_RdData;
      valid_reg <= 1'b1;
    end else if (handshake) begin
      valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc_reg <= RESET_PC;
    end else if (handshake) begin
      pc_reg <= pc_nxt;
    end
  end

  assign Imem_Req    = req_reg;
  assign Imem_Addr   = pc_reg;
  assign Instr       = instr_reg;
  assign Instr_Valid = valid_reg;
  assign PC          = pc_reg;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit with a behavioural instruction memory.
`default_nettype none

module tb_instr_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        PC_sel;
  logic        PC_LdEn;
  logic [31:0] PC_Immed;
  logic        Imem_Req;
  logic [31:0] Imem_Addr;
  logic        Imem_Ack;
  logic [31:0] Imem_RdData;
  logic [31:0] Instr;
  logic        Instr_Valid;
  logic        Instr_Ready;
  logic [31:0] PC;

  int          tests = 0;
  int          fails = 0;
  int          ack_delay = 0;
  int          cnt;
  logic        force_ack = 1'b0;
  logic [31:0] rd_flip = 32'h0;

  always #5 Clk = ~Clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h8000_1111;
  endfunction

  // Memory acks after ack_delay cycles of continuous request.
  assign Imem_Ack    = force_ack | (Imem_Req && (cnt == ack_delay));
  assign Imem_RdData = mem_word(Imem_Addr) ^ rd_flip;

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) cnt <= 0;
    else if (Imem_Req && !Imem_Ack) cnt <= cnt + 1;
    else cnt <= 0;
  end

  instr_fetch_unit dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .PC_sel      (PC_sel),
    .PC_LdEn     (PC_LdEn),
    .PC_Immed    (PC_Immed),
    .Imem_Req    (Imem_Req),
    .Imem_Addr   (Imem_Addr),
    .Imem_Ack    (Imem_Ack),
    .Imem_RdData (Imem_RdData),
    .Instr       (Instr),
    .Instr_Valid (Instr_Valid),
    .Instr_Ready (Instr_Ready),
    .PC          (PC)
  );

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (Imem_Req) begin ok = 1'b1; break; end
      @(negedge Clk);
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (Instr_Valid) begin ok = 1'b1; break; end
      @(negedge Clk);
    end
  endtask

  // Called at a negedge with Instr_Valid=1; the handshake happens on the next posedge.
  task automatic do_handshake(input logic sel, input logic ld, input logic [31:0] imm);
    PC_sel = sel; PC_LdEn = ld; PC_Immed = imm; Instr_Ready = 1'b1;
    @(negedge Clk);
    Instr_Ready = 1'b0; PC_sel = 1'b0; PC_LdEn = 1'b1; PC_Immed = 32'h0;
  endtask

  task automatic test_reset;
    Reset = 1'b0; PC_sel = 1'b0; PC_LdEn = 1'b1; PC_Immed = 32'h0; Instr_Ready = 1'b0;
    repeat (2) @(negedge Clk);
    tests++;
    if (Imem_Req !== 1'b0 || Instr_Valid !== 1'b0 || Instr !== 32'h0 || PC !== 32'h0) begin
      fails++;
      $display("FAIL reset_state: req=%b valid=%b instr=%h pc=%h, required 0/0/0/0",
               Imem_Req, Instr_Valid, Instr, PC);
    end
    Reset = 1'b1;
    @(negedge Clk);
    tests++;
    if (Imem_Req !== 1'b0) begin
      fails++;
      $display("FAIL req_latency_low: req=%b, required 0", Imem_Req);
    end
    @(negedge Clk);
    tests++;
    if (Imem_Req !== 1'b1 || Imem_Addr !== 32'h0) begin
      fails++;
      $display("FAIL req_latency_high: req=%b addr=%h, required 1/00000000", Imem_Req, Imem_Addr);
    end
  endtask

  task automatic test_sequential;
    bit ok;
    Instr_Ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_req(ok);
      tests++;
      if (!ok || Imem_Addr !== 32'(i * 4)) begin
        fails++;
        $display("FAIL seq_addr[%0d]: ok=%b addr=%h, required %h", i, ok, Imem_Addr, 32'(i * 4));
      end
      wait_valid(ok);
      tests++;
      if (!ok || Instr !== mem_word(32'(i * 4)) || PC !== 32'(i * 4)) begin
        fails++;
        $display("FAIL seq_instr[%0d]: ok=%b instr=%h pc=%h, required %h/%h",
                 i, ok, Instr, PC, mem_word(32'(i * 4)), 32'(i * 4));
      end
      if (i == 3) Instr_Ready = 1'b0;
    end
  endtask

  task automatic test_ack_delay;
    bit ok;
    ack_delay = 5;
    do_handshake(1'b0, 1'b1, 32'h0);
    wait_req(ok);
    for (int k = 0; k < 5; k++) begin
      tests++;
      if (!ok || Imem_Req !== 1'b1 || Imem_Addr !== 32'h10 || Instr_Valid !== 1'b0 || Imem_Ack !== 1'b0) begin
        fails++;
        $display("FAIL ack_wait[%0d]: req=%b addr=%h valid=%b ack=%b, required 1/00000010/0/0",
                 k, Imem_Req, Imem_Addr, Instr_Valid, Imem_Ack);
      end
      @(negedge Clk);
    end
    tests++;
    if (Imem_Req !== 1'b1 || Imem_Ack !== 1'b1 || Instr_Valid !== 1'b0) begin
      fails++;
      $display("FAIL ack_cycle: req=%b ack=%b valid=%b, required 1/1/0", Imem_Req, Imem_Ack, Instr_Valid);
    end
    @(negedge Clk);
    tests++;
    if (Instr_Valid !== 1'b1 || Instr !== mem_word(32'h10) || Imem_Req !== 1'b0) begin
      fails++;
      $display("FAIL ack_valid: valid=%b instr=%h req=%b, required 1/%h/0",
               Instr_Valid, Instr, Imem_Req, mem_word(32'h10));
    end
    ack_delay = 0;
  endtask

  task automatic test_branch;
    bit ok;
    do_handshake(1'b1, 1'b1, 32'hFFFF_FFFE);
    wait_req(ok);
    tests++;
    if (!ok || Imem_Addr !== 32'h0C) begin
      fails++;
      $display("FAIL branch_back_addr: ok=%b addr=%h, required 0000000c", ok, Imem_Addr);
    end
    wait_valid(ok);
    tests++;
    if (!ok || PC !== 32'h0C || Instr !== mem_word(32'h0C)) begin
      fails++;
      $display("FAIL branch_back_instr: pc=%h instr=%h, required 0000000c/%h", PC, Instr, mem_word(32'h0C));
    end
  endtask

  task automatic test_hold_pc;
    bit ok;
    do_handshake(1'b1, 1'b1, 32'd4);
    wait_valid(ok);
    tests++;
    if (!ok || PC !== 32'h20) begin
      fails++;
      $display("FAIL branch_fwd_pc: pc=%h, required 00000020", PC);
    end
    do_handshake(1'b0, 1'b0, 32'h0);
    wait_req(ok);
    tests++;
    if (!ok || Imem_Addr !== 32'h20) begin
      fails++;
      $display("FAIL refetch_addr: addr=%h, required 00000020", Imem_Addr);
    end
    wait_valid(ok);
    tests++;
    if (!ok || PC !== 32'h20 || Instr !== mem_word(32'h20)) begin
      fails++;
      $display("FAIL refetch_instr: pc=%h instr=%h, required 00000020/%h", PC, Instr, mem_word(32'h20));
    end
  endtask

  task automatic test_stall;
    force_ack = 1'b1;
    rd_flip   = 32'hFFFF_0000;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      tests++;
      if (Instr_Valid !== 1'b1 || Instr !== mem_word(32'h20) || PC !== 32'h20 || Imem_Req !== 1'b0) begin
        fails++;
        $display("FAIL stall[%0d]: valid=%b instr=%h pc=%h req=%b, required 1/%h/00000020/0",
                 k, Instr_Valid, Instr, PC, Imem_Req, mem_word(32'h20));
      end
    end
    force_ack = 1'b0;
    rd_flip   = 32'h0;
  endtask

  task automatic test_wrap_and_reset;
    bit ok;
    do_handshake(1'b1, 1'b1, 32'hFFFF_FFF6);
    wait_valid(ok);
    tests++;
    if (!ok || PC !== 32'hFFFF_FFFC || Instr !== mem_word(32'hFFFF_FFFC)) begin
      fails++;
      $display("FAIL top_pc: pc=%h instr=%h, required fffffffc/%h", PC, Instr, mem_word(32'hFFFF_FFFC));
    end
    ack_delay = 5;
    do_handshake(1'b0, 1'b1, 32'h0);
    wait_req(ok);
    tests++;
    if (!ok || Imem_Addr !== 32'h0) begin
      fails++;
      $display("FAIL wrap_addr: addr=%h, required 00000000", Imem_Addr);
    end
    #2 Reset = 1'b0;
    #1;
    tests++;
    if (Imem_Req !== 1'b0 || Instr !== 32'h0 || Instr_Valid !== 1'b0 || PC !== 32'h0) begin
      fails++;
      $display("FAIL async_reset: req=%b instr=%h valid=%b pc=%h, required 0/0/0/0",
               Imem_Req, Instr, Instr_Valid, PC);
    end
    ack_delay = 0;
    @(negedge Clk);
    Reset = 1'b1;
    wait_req(ok);
    wait_valid(ok);
    tests++;
    if (!ok || PC !== 32'h0 || Instr !== mem_word(32'h0)) begin
      fails++;
      $display("FAIL post_reset_fetch: pc=%h instr=%h, required 00000000/%h", PC, Instr, mem_word(32'h0));
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_ack_delay();
    test_branch();
    test_hold_pc();
    test_stall();
    test_wrap_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
